usb_tx: RTL and testbench
=========================

# usb_tx

USB full-speed packet transmitter: the transmit-side counterpart of the receive path in the USB/SD bulk-transfer bridge. On a one-cycle start request it serializes one handshake packet (ACK/NAK) or one data packet (DATA0/DATA1) onto the bus. A data packet carries a payload drained from the TX FIFO plus a CRC16. Serialization covers SYNC, PID, bit stuffing, NRZI encoding and EOP, and the transmit controller sequences it.

## Interface
Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; ≥2
- MAX_BYTES, 64, maximum data payload bytes per packet

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_start  in  1  one-cycle request; sampled only in IDLE
- tx_pckt  in  2  packet type: 00 ACK, 01 NAK, 10 DATA0, 11 DATA1; sampled with tx_start
- tx_data  in  8  head byte of TX FIFO (first-word fall-through)
- fifo_empty  in  1  TX FIFO empty
- get_tx_data  out  1  one-cycle FIFO pop
- d_plus  out  1  bus D+
- d_minus  out  1  bus D−
- d_mode  out  1  1 while driving the bus (SYNC through final J)
- tx_busy  out  1  1 from cycle after accepted tx_start until tx_done
- tx_done  out  1  one-cycle pulse at packet completion

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- IDLE → SYNC on tx_start; tx_pckt is latched.
- SYNC → PID after 8 bits. PID → DATA (DATA0/1) or EOP_SE0 (ACK/NAK) after 8 bits.
- DATA → CRC_LO when a byte completes and either fifo_empty=1 or MAX_BYTES have been sent.
- PID → CRC_LO directly if fifo_empty=1 when PID completes, giving a zero-length packet.
- CRC_LO → CRC_HI → EOP_SE0 (2 bit times) → EOP_J (1 bit time) → IDLE.
- SYNC byte is 0x80, sent LSB first (seven 0s then a 1).
- PID byte is {~pid, pid}: ACK 0xD2, NAK 0x5A, DATA0 0xC3, DATA1 0x4B.
- All bytes are sent LSB first.
- Payload fetch: at the start of each DATA byte, tx_data is loaded into the shift register and get_tx_data pulses once. fifo_empty is checked only at byte boundaries.
- CRC16 algorithm: reflected polynomial 0xA001, init 0xFFFF, updated per payload bit (pre-stuffing), reset at SYNC.
- CRC16 transmission: ~crc is sent, low byte then high byte, LSB first.
- Bit stuffing:
  - A ones counter covers SYNC through the last CRC bit.
  - After six consecutive 1s, the next bit slot carries a stuffed 0. The shift register and CRC hold for that slot, and the counter clears.
  - A stuff bit owed after the final PID/CRC bit is sent before EOP.
- NRZI: a 0 toggles the line; a 1 holds it. Line state starts at J at SYNC.
- Bus levels: J = (d_plus 1, d_minus 0); K = (0,1); SE0 = (0,0).
- When d_mode=0 the outputs are J.
- tx_start while tx_busy=1 is ignored.
- tx_pckt changes after acceptance have no effect.

## Timing
- Reset values: d_plus 1, d_minus 0, d_mode 0, tx_busy 0, tx_done 0, get_tx_data 0. State is IDLE; counters and CRC are cleared.
- rst asserted mid-packet aborts it. Outputs return to reset values at the next edge, no tx_done is generated, and no further pops occur.
- The bit timer counts 0..CLKS_PER_BIT−1, and each bit is held for exactly CLKS_PER_BIT cycles.
- Start latency: the first SYNC bit appears on d_plus/d_minus in the cycle after tx_start is sampled high. d_mode and tx_busy rise in that same cycle.
- get_tx_data pulses in the first cycle of each payload byte's first bit time. The FIFO updates tx_data by the next cycle.
- Total bits on the wire = 8·(2 + payload + 2·isData) + stuff bits + 3.
- Handshake packet: 19 bit times = 19·CLKS_PER_BIT cycles, unstuffed.
- End of packet: tx_done pulses, and d_mode and tx_busy fall, in the cycle after the last EOP_J cycle. The bus stays J.
- A new tx_start is accepted in the same cycle as tx_done.

## Test plan
- ACK, CLKS_PER_BIT=8:
  - Stimulus: tx_start with tx_pckt=00.
  - Response: NRZI-decoded stream is 0x80, 0xD2, then 2 SE0 bit times, then 1 J bit time. tx_done pulses 152 cycles after the first SYNC bit. No get_tx_data.
- DATA0, zero-length, fifo_empty=1:
  - Response: PID 0xC3, CRC bytes 0x00 0x00, EOP. Zero get_tx_data pulses.
- DATA1, FIFO holding 0xFF 0xFF then empty:
  - Response: stuffed 0 after the 6th and 12th payload ones. Destuffed bytes are 0x4B FF FF plus a CRC that matches the reference model. Exactly 2 pops.
- DATA0, FIFO holding 70 bytes:
  - Response: exactly 64 get_tx_data pulses. CRC covers the first 64 bytes; 6 bytes remain in the FIFO.
- rst at the 3rd payload byte:
  - Response: next edge gives J, d_mode=0, tx_busy=0, no tx_done.
  - A tx_start pulsed mid-packet (no reset) is ignored and the packet completes unchanged.

Source files
------------

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: serializes ACK/NAK handshakes and DATA0/DATA1
// packets (payload from a fall-through FIFO plus CRC16) with bit stuffing, NRZI and EOP.
module usb_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [1:0] tx_pckt,
  input  logic [7:0] tx_data,
  input  logic       fifo_empty,
  output logic       get_tx_data,
  output logic       d_plus,
  output logic       d_minus,
  output logic       d_mode,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] LASTCLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] MAXB    = BW'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J} state_t;

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    ones;
  logic [7:0]    shreg;
  logic [15:0]   crc;
  logic [BW-1:0] byte_cnt;
  logic [1:0]    pckt;
  logic          stuff, last, line;

  logic          bit_end, serial, cur_bit, owe, adv, fb;
  logic [15:0]   crc_next, crc_fin;
  logic [3:0]    pid;

  always_comb begin
    bit_end  = (bit_cnt == LASTCLK);
    serial   = (state != IDLE) && (state != EOP_SE0) && (state != EOP_J);
    cur_bit  = stuff ? 1'b0 : shreg[0];
    owe      = !stuff && cur_bit && (ones == 3'd5);
    fb       = crc[0] ^ cur_bit;
    crc_next = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    crc_fin  = (state == DATA && !stuff) ? crc_next : crc;
    case (pckt)
      2'b00:   pid = 4'h2;
      2'b01:   pid = 4'hA;
      2'b10:   pid = 4'h3;
      default: pid = 4'hB;
    endcase
    // A byte whose last bit owes a stuff 0 only finishes after that stuff slot.
    case (state)
      IDLE:    adv = 1'b0;
      EOP_SE0: adv = bit_end && bit_idx[0];
      EOP_J:   adv = bit_end;
      default: adv = bit_end && (stuff ? last : (bit_idx == 3'd7 && !owe));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tx_start) state_n = SYNC;
      SYNC:    if (adv) state_n = PID;
      PID:     if (adv) state_n = !pckt[1] ? EOP_SE0 : (fifo_empty ? CRC_LO : DATA);
      DATA:    if (adv && (fifo_empty || byte_cnt == MAXB)) state_n = CRC_LO;
      CRC_LO:  if (adv) state_n = CRC_HI;
      CRC_HI:  if (adv) state_n = EOP_SE0;
      EOP_SE0: if (adv) state_n = EOP_J;
      EOP_J:   if (adv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    d_mode  = (state != IDLE);
    tx_busy = (state != IDLE);
    case (state)
      IDLE:    begin d_plus = 1'b1; d_minus = 1'b0; end
      EOP_SE0: begin d_plus = 1'b0; d_minus = 1'b0; end
      EOP_J:   begin d_plus = 1'b1; d_minus = 1'b0; end
      default: begin
        d_plus  = cur_bit ? line : ~line;
        d_minus = ~d_plus;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      bit_idx     <= '0;
      ones        <= '0;
      shreg       <= '0;
      crc         <= '0;
      byte_cnt    <= '0;
      pckt        <= '0;
      stuff       <= 1'b0;
      last        <= 1'b0;
      line        <= 1'b1;
      get_tx_data <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      get_tx_data <= 1'b0;
      tx_done     <= 1'b0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (tx_start) begin
          pckt     <= tx_pckt;
          shreg    <= 8'h80;
          crc      <= '1;
          ones     <= '0;
          stuff    <= 1'b0;
          last     <= 1'b0;
          bit_idx  <= '0;
          byte_cnt <= '0;
          line     <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (bit_end) begin
          if (serial) line <= cur_bit ? line : ~line;
          if (serial && stuff) begin
            stuff <= 1'b0;
            ones  <= '0;
          end else if (serial) begin
            ones    <= cur_bit ? ones + 3'd1 : '0;
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (state == DATA) crc <= crc_next;
            if (owe) stuff <= 1'b1;
            if (owe && bit_idx == 3'd7) last <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
          if (adv) begin
            bit_idx <= '0;
            last    <= 1'b0;
            case (state_n)
              PID:    shreg <= {~pid, pid};
              DATA: begin
                shreg       <= tx_data;
                byte_cnt    <= byte_cnt + 1'b1;
                get_tx_data <= 1'b1;
              end
              CRC_LO: shreg <= ~crc_fin[7:0];
              CRC_HI: shreg <= ~crc[15:8];
              IDLE:   tx_done <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: a reference packet model fills a scoreboard of
// expected bus symbols per bit time, compared mid-bit against d_plus/d_minus.
module tb_usb_tx;
  localparam int unsigned CPB  = 8;
  localparam int unsigned MAXB = 64;

  logic       clk = 1'b0;
  logic       rst, tx_start, fifo_empty;
  logic [1:0] tx_pckt;
  logic [7:0] tx_data;
  logic       get_tx_data, d_plus, d_minus, d_mode, tx_busy, tx_done;

  always #5 clk = ~clk;

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pckt(tx_pckt),
    .tx_data(tx_data), .fifo_empty(fifo_empty), .get_tx_data(get_tx_data),
    .d_plus(d_plus), .d_minus(d_minus), .d_mode(d_mode),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // FIFO model: bench writes, pop process advances the read pointer
  logic [7:0]  mem [0:511];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pops = 0;
  logic        flush = 1'b0;
  assign tx_data    = mem[rd_ptr[8:0]];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (get_tx_data) begin
      pops <= pops + 1;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  sb [$];
  logic [7:0]  pay [$];
  logic [7:0]  stim [$];

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic build_expected(input logic [1:0] p);
    logic [7:0] bytes [$];
    logic [7:0] pidb;
    logic [7:0] byt;
    logic [15:0] crc;
    int unsigned ones;
    logic lvl, b;
    case (p)
      2'b00:   pidb = 8'hD2;
      2'b01:   pidb = 8'h5A;
      2'b10:   pidb = 8'hC3;
      default: pidb = 8'h4B;
    endcase
    bytes.push_back(8'h80);
    bytes.push_back(pidb);
    if (p[1]) begin
      crc = 16'hFFFF;
      foreach (pay[k]) begin
        byt = pay[k];
        for (int j = 0; j < 8; j++) begin
          b = byt[j];
          if (crc[0] ^ b) crc = (crc >> 1) ^ 16'hA001;
          else            crc = crc >> 1;
        end
        bytes.push_back(byt);
      end
      crc = ~crc;
      bytes.push_back(crc[7:0]);
      bytes.push_back(crc[15:8]);
    end
    ones = 0;
    lvl  = 1'b1;
    foreach (bytes[k]) begin
      byt = bytes[k];
      for (int j = 0; j < 8; j++) begin
        b = byt[j];
        if (!b) lvl = ~lvl;
        sb.push_back({lvl, ~lvl});
        if (b) begin
          ones++;
          if (ones == 6) begin
            lvl = ~lvl;
            sb.push_back({lvl, ~lvl});
            ones = 0;
          end
        end else ones = 0;
      end
    end
    sb.push_back(2'b00);
    sb.push_back(2'b00);
    sb.push_back(2'b10);
  endtask

  // Sends one packet; returns in the tx_done cycle so a caller may chain the next start.
  task automatic run_packet(input logic [1:0] p, input bit poke, input string tag);
    int unsigned nbits, pops0, exp_pops;
    logic [1:0] exp, got;
    pay.delete();
    foreach (stim[k]) begin
      mem[wr_ptr[8:0]] = stim[k];
      wr_ptr++;
      if (p[1] && k < int'(MAXB)) pay.push_back(stim[k]);
    end
    exp_pops = pay.size();
    build_expected(p);
    nbits = sb.size();
    pops0 = pops;
    tx_pckt  = p;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    checks++;
    if ({d_mode, tx_busy, tx_done, d_plus, d_minus} !== 5'b11001) begin
      errors++;
      $display("FAIL %s start: {mode,busy,done,dp,dm}=%b expected 11001", tag,
               {d_mode, tx_busy, tx_done, d_plus, d_minus});
    end
    tick(CPB / 2);
    for (int i = 0; i < int'(nbits); i++) begin
      exp = sb.pop_front();
      got = {d_plus, d_minus};
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors < 30) $display("FAIL %s bit %0d: got %b expected %b", tag, i, got, exp);
      end
      if (i < int'(nbits) - 1) begin
        if (poke && i == 10) begin
          tx_start = 1'b1;
          tx_pckt  = ~p;
          tick(1);
          tx_start = 1'b0;
          tick(CPB - 1);
        end else tick(CPB);
      end
    end
    tick(CPB / 2 - 1);
    checks++;
    if (tx_done !== 1'b0 || d_mode !== 1'b1) begin
      errors++;
      $display("FAIL %s before_done: done=%b mode=%b expected 0 1", tag, tx_done, d_mode);
    end
    tick(1);
    checks++;
    if ({tx_done, d_mode, tx_busy, d_plus, d_minus} !== 5'b10010) begin
      errors++;
      $display("FAIL %s done: {done,mode,busy,dp,dm}=%b expected 10010", tag,
               {tx_done, d_mode, tx_busy, d_plus, d_minus});
    end
    checks++;
    if (pops - pops0 != exp_pops) begin
      errors++;
      $display("FAIL %s pops: got %0d expected %0d", tag, pops - pops0, exp_pops);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; tx_pckt = 2'b00;
    tick(3);
    checks++;
    if ({d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_held: outputs=%b expected 100000",
               {d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data});
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if ({d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_idle: outputs=%b expected 100000",
               {d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data});
    end
  endtask

  task automatic test_handshake();
    stim.delete();
    run_packet(2'b00, 1'b0, "ack");
    tick(5);
    run_packet(2'b01, 1'b1, "nak_ignored_start");
    tick(5);
  endtask

  task automatic test_zero_length();
    stim.delete();
    run_packet(2'b10, 1'b0, "data0_zlp");
    tick(5);
  endtask

  task automatic test_stuffing();
    stim.delete();
    stim.push_back(8'hFF);
    stim.push_back(8'hFF);
    run_packet(2'b11, 1'b0, "data1_stuff");
    tick(5);
  endtask

  task automatic test_max_bytes();
    stim.delete();
    for (int i = 0; i < 70; i++) stim.push_back(8'($urandom));
    run_packet(2'b10, 1'b0, "data0_max");
    checks++;
    if (wr_ptr - rd_ptr != 6) begin
      errors++;
      $display("FAIL max_left: fifo holds %0d expected 6", wr_ptr - rd_ptr);
    end
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(5);
  endtask

  task automatic test_mid_reset();
    int unsigned pops0, pops1, n;
    bit seen;
    for (int i = 0; i < 5; i++) begin
      mem[wr_ptr[8:0]] = 8'($urandom);
      wr_ptr++;
    end
    pops0 = pops;
    tx_pckt = 2'b10; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    n = 0;
    while (pops - pops0 < 3 && n < 3000) begin tick(1); n++; end
    checks++;
    if (pops - pops0 != 3) begin
      errors++;
      $display("FAIL midrst_wait: pops %0d expected 3 within bound", pops - pops0);
    end
    tick(12);
    rst = 1'b1; tick(1); rst = 1'b0;
    checks++;
    if ({d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data} !== 6'b100000) begin
      errors++;
      $display("FAIL midrst_out: outputs=%b expected 100000",
               {d_plus, d_minus, d_mode, tx_busy, tx_done, get_tx_data});
    end
    pops1 = pops;
    seen  = 1'b0;
    repeat (300) begin
      tick(1);
      if (tx_done || d_mode || tx_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_quiet: activity seen=%b expected 0", seen);
    end
    checks++;
    if (pops != pops1) begin
      errors++;
      $display("FAIL midrst_pops: got %0d extra pops expected 0", pops - pops1);
    end
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(5);
  endtask

  task automatic test_back_to_back();
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
    run_packet(2'b11, 1'b0, "b2b_data1");
    stim.delete();
    run_packet(2'b00, 1'b0, "b2b_ack");
    tick(5);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_zero_length();
    test_stuffing();
    test_max_bytes();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
